// File: rtl/song_reader.sv
// Song reader: walks one song's note ROM entry by entry and hands each note to the
// note player over a new_note/note_done handshake, then pulses song_done.
module song_reader #(
    parameter int unsigned NOTE_ADDR_W = 5,
    parameter int unsigned NOTE_W      = 6,
    parameter int unsigned DUR_W       = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      play,
    input  logic [1:0]                song,
    input  logic                      note_done,
    output logic [NOTE_ADDR_W+1:0]    rom_addr,
    input  logic [NOTE_W+DUR_W-1:0]   rom_data,
    output logic [NOTE_W-1:0]         note,
    output logic [DUR_W-1:0]          duration,
    output logic                      new_note,
    output logic                      song_done
);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StEmit,
        StWaitNote,
        StDone
    } state_e;

    localparam logic [NOTE_ADDR_W-1:0] IdxMax = '1;

    state_e                   state_q, state_d;
    logic [NOTE_ADDR_W-1:0]   idx_q, idx_d;
    logic [1:0]               song_q, song_d;
    logic [NOTE_W-1:0]        note_q, note_d;
    logic [DUR_W-1:0]         dur_q, dur_d;
    logic                     done_seen_q, done_seen_d;

    logic [NOTE_W-1:0]        rom_note;
    logic [DUR_W-1:0]         rom_dur;

    assign rom_note = rom_data[NOTE_W+DUR_W-1:DUR_W];
    assign rom_dur  = rom_data[DUR_W-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            song_q      <= '0;
            note_q      <= '0;
            dur_q       <= '0;
            done_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            song_q      <= song_d;
            note_q      <= note_d;
            dur_q       <= dur_d;
            done_seen_q <= done_seen_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        song_d      = song_q;
        note_d      = note_q;
        dur_d       = dur_q;
        done_seen_d = done_seen_q;

        unique case (state_q)
            StIdle: begin
                if (play) begin
                    state_d = StFetch;
                    // Song is latched only at the start of a song.
                    if (idx_q == '0) begin
                        song_d = song;
                    end
                end
            end
            StFetch: begin
                note_d  = rom_note;
                dur_d   = rom_dur;
                state_d = (rom_dur == '0) ? StDone : StEmit;
            end
            StEmit: begin
                state_d = StWaitNote;
            end
            StWaitNote: begin
                if (note_done) begin
                    if (idx_q == IdxMax) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StDone: begin
                done_seen_d = 1'b1;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign rom_addr  = {song_q, idx_q};
    assign note      = note_q;
    assign duration  = dur_q;
    assign new_note  = (state_q == StEmit);
    // Pulse only on the first cycle spent in DONE.
    assign song_done = (state_q == StDone) && !done_seen_q;

endmodule

// File: tb/tb_song_reader.sv
// Randomized bench for song_reader: plays songs from a bench-filled ROM and checks every
// note hand-off, pause, song end and reset against the expected note sequence.
module tb_song_reader;

    localparam int unsigned AW    = 5;
    localparam int unsigned NW    = 6;
    localparam int unsigned DW    = 6;
    localparam int unsigned DEPTH = 1 << AW;

    logic              clk = 1'b0;
    logic              reset;
    logic              play;
    logic [1:0]        song;
    logic              note_done;
    logic [AW+1:0]     rom_addr;
    logic [NW+DW-1:0]  rom_data;
    logic [NW-1:0]     note;
    logic [DW-1:0]     duration;
    logic              new_note;
    logic              song_done;

    logic [NW+DW-1:0]  rom [4*DEPTH];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Idealised ROM: data for the FETCH-cycle address is settled by the end of FETCH.
    assign rom_data = rom[rom_addr];

    song_reader #(
        .NOTE_ADDR_W(AW),
        .NOTE_W     (NW),
        .DUR_W      (DW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .play     (play),
        .song     (song),
        .note_done(note_done),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .note     (note),
        .duration (duration),
        .new_note (new_note),
        .song_done(song_done)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW+1:0] addr_of(input int s, input int i);
        logic [1:0]    sb;
        logic [AW-1:0] ib;
        sb = s[1:0];
        ib = i[AW-1:0];
        return {sb, ib};
    endfunction

    task automatic check_quiet(input string tag);
        check_eq({tag, " new_note"}, 32'(new_note), 32'd0);
        check_eq({tag, " song_done"}, 32'(song_done), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, " note"}, 32'(note), 32'd0);
        check_eq({tag, " duration"}, 32'(duration), 32'd0);
        check_eq({tag, " rom_addr"}, 32'(rom_addr), 32'd0);
        check_quiet(tag);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        play      = 1'($urandom);
        note_done = 1'($urandom);
        tick();
        check_reset_vals("reset");
        reset     = 1'b0;
        play      = 1'b0;
        note_done = 1'b0;
    endtask

    // Plays song s whose first zero-duration entry is at index term (term==DEPTH: none).
    task automatic run_song(input int s, input int term, input bit directed);
        int               idx;
        int               p;
        int               d;
        bit               fin;
        logic [NW+DW-1:0] e;

        for (int i = 0; i < 4 * DEPTH; i++) begin
            rom[i][NW+DW-1:DW] = NW'($urandom);
            rom[i][DW-1:0]     = DW'($urandom_range(1, (1 << DW) - 1));
        end
        if (directed) rom[addr_of(s, 0)] = {6'd10, 6'd4};
        if (term < DEPTH) rom[addr_of(s, term)][DW-1:0] = '0;

        song = 2'($urandom);
        do_reset();
        song = s[1:0];
        idx  = 0;
        fin  = 1'b0;
        p    = $urandom_range(0, 2);

        while (!fin) begin
            for (int j = 0; j < p; j++) begin
                play      = 1'b0;
                note_done = 1'($urandom);
                tick();
                check_quiet("pause");
            end
            play      = 1'b1;
            note_done = 1'($urandom);
            tick();
            check_quiet("fetch");
            note_done = 1'($urandom);
            song      = 2'($urandom);
            tick();
            e = rom[addr_of(s, idx)];
            check_eq("note", 32'(note), 32'(e[NW+DW-1:DW]));
            check_eq("duration", 32'(duration), 32'(e[DW-1:0]));
            check_eq("rom_addr", 32'(rom_addr), 32'(addr_of(s, idx)));
            if (idx >= term) begin
                check_eq("end-marker song_done", 32'(song_done), 32'd1);
                check_eq("end-marker new_note", 32'(new_note), 32'd0);
                fin = 1'b1;
            end else begin
                check_eq("new_note", 32'(new_note), 32'd1);
                check_eq("new_note song_done", 32'(song_done), 32'd0);
                note_done = 1'($urandom);
                tick();
                check_quiet("emit");
                note_done = 1'b0;
                d = $urandom_range(0, 5);
                for (int j = 0; j < d; j++) begin
                    play = 1'($urandom);
                    tick();
                    check_quiet("wait");
                end
                p    = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                play = (p == 0);
                note_done = 1'b1;
                tick();
                note_done = 1'b0;
                if (idx == DEPTH - 1) begin
                    check_eq("last song_done", 32'(song_done), 32'd1);
                    check_eq("last new_note", 32'(new_note), 32'd0);
                    fin = 1'b1;
                end else begin
                    check_quiet("idle");
                    idx++;
                end
            end
        end

        for (int j = 0; j < 4; j++) begin
            note_done = 1'($urandom);
            play      = 1'($urandom);
            song      = 2'($urandom);
            tick();
            check_quiet("done");
            check_eq("done rom_addr", 32'(rom_addr), 32'(addr_of(s, idx)));
        end
        note_done = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4 * DEPTH; i++) rom[i] = '0;
        reset     = 1'b1;
        play      = 1'b0;
        song      = 2'd0;
        note_done = 1'b0;
        tick();
        check_reset_vals("init");
        reset = 1'b0;

        run_song(2, 3, 1'b1);
        run_song(1, 1, 1'b0);
        run_song(3, DEPTH, 1'b0);
        run_song(0, 0, 1'b0);

        // Reset mid-note, then a fresh start must re-sample song.
        song = 2'd1;
        do_reset();
        play = 1'b1;
        tick();
        tick();
        check_eq("mid new_note", 32'(new_note), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        check_reset_vals("mid reset");
        reset = 1'b0;
        song  = 2'd3;
        play  = 1'b1;
        tick();
        check_eq("restart rom_addr", 32'(rom_addr), 32'h60);
        tick();
        check_eq("restart new_note", 32'(new_note), 32'd1);
        check_eq("restart note", 32'(note), 32'(rom[7'h60][NW+DW-1:DW]));

        for (int r = 0; r < 4; r++) begin
            run_song($urandom_range(0, 3), $urandom_range(0, DEPTH), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/song_reader.md
Name: song_reader

Overview:
- Player-side counterpart of the MCU control interface.
- Consumes play, song and the MCU's player reset. Walks the selected song's note ROM one entry at a time and hands each note to the note player via a new_note/note_done handshake.
- Pulses song_done back to the MCU when the song ends.
- Sits between the MCU, the song ROM and the note player.

Parameters:
- NOTE_ADDR_W, 5, address bits per song; each song holds 2^NOTE_ADDR_W entries (default 32)
- NOTE_W, 6, width of note field in ROM word and on note output
- DUR_W, 6, width of duration field in ROM word and on duration output

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high; driven by global reset OR MCU reset_player
- play  input  1  1 = advance through song, 0 = pause between notes
- song  input  2  song select from MCU
- note_done  input  1  one-cycle pulse from note player: current note finished
- rom_addr  output  2+NOTE_ADDR_W  {song_q, idx} to song ROM
- rom_data  input  NOTE_W+DUR_W  {note, duration}; synchronous ROM, valid 1 cycle after address
- note  output  NOTE_W  current note, held until next note issued
- duration  output  DUR_W  current duration, held until next note issued
- new_note  output  1  one-cycle pulse: note/duration valid for a new note
- song_done  output  1  one-cycle pulse: song finished

Behaviour:
- Reset (synchronous, active-high, overrides all other inputs):
  - state=IDLE, idx=0, song_q=0.
  - note=0, duration=0, new_note=0, song_done=0, rom_addr=0.
- rom_addr is combinational {song_q, idx}, always driven.
- States: IDLE, FETCH, EMIT, WAIT_NOTE, DONE.
- IDLE:
  - If play=1: go to FETCH.
  - If idx==0 on that transition, song_q<=song. Song changes after that are ignored until the next reset.
- FETCH: one cycle for ROM latency. On exit, capture rom_data into note/duration.
  - If the captured duration==0 (end-of-song marker): go to DONE; note/duration still load.
  - Otherwise: go to EMIT.
- EMIT: new_note=1 for exactly this cycle, then go to WAIT_NOTE.
- WAIT_NOTE: wait for note_done=1.
  - If idx==2^NOTE_ADDR_W-1: go to DONE.
  - Otherwise: idx<=idx+1 and go to IDLE.
- play=0 during FETCH, EMIT or WAIT_NOTE does not stall those states. Pausing takes effect only in IDLE, between notes.
- note_done outside WAIT_NOTE is ignored; it is not queued.
- DONE:
  - song_done=1 only in the first cycle after entry; stays in DONE with song_done=0 until reset.
  - new_note is never asserted in DONE.
  - idx does not wrap; only reset leaves DONE.
- Latency: play first sampled high at edge k (state IDLE) -> FETCH after edge k -> new_note high in the cycle after edge k+1.
  - Between notes: note_done sampled at edge m -> new_note high after edge m+2, provided play=1 in IDLE.
- Reset mid-note, in any state: immediate return to reset values. Next play restarts from idx 0 and re-samples song.
- new_note and song_done are never both 1 in the same cycle.

Test Plan:
- Reset then play=1, song=2, ROM[{2,0}]={note 10, dur 4} -> rom_addr=0x40; new_note pulses 2 edges after play, with note=10 and duration=4; rom_addr=0x40 throughout.
- Handshake over 3 notes, note_done pulsed 5 cycles after each new_note -> idx 0,1,2 and exactly one new_note per note, each 2 edges after the prior note_done.
- ROM entry 1 has duration=0 -> after note 0's note_done, song_done pulses for 1 cycle, no second new_note, state stays DONE; extra note_done pulses produce nothing.
- Full song with no zero duration -> 32 new_note pulses, then song_done 1 cycle after the 32nd note_done; idx does not wrap.
- play=0 asserted during WAIT_NOTE, note_done arrives -> no new_note until play=1; new_note then follows 2 edges after play returns.
- Song changed to 3 mid-song without reset -> rom_addr upper bits stay at the original song. Reset, then play -> song_q=3, rom_addr=0x60.
